// File: rtl/serial_pair_serializer.sv
// rtl/serial_pair_serializer.sv - two-operand parallel-to-serial transmitter with comparator clear pulse
module serial_pair_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             cmp_rst,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             at_last;
    logic             xfer;
    logic             head_a;
    logic             head_b;

    // The last-bit cycle doubles as an accept slot so back-to-back words only pay for CLR
    assign at_last = (state == SHIFT) && (cnt == LAST_BIT);
    assign xfer    = in_valid && in_ready;
    assign head_a  = MSB_FIRST ? sh_a[WIDTH-1] : sh_a[0];
    assign head_b  = MSB_FIRST ? sh_b[WIDTH-1] : sh_b[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (xfer) state_nx = CLR;
            CLR:     state_nx = SHIFT;
            SHIFT: begin
                if (at_last) begin
                    state_nx = xfer ? CLR : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from registered state only; rst forces a quiet, clearing interface
    always_comb begin
        in_ready  = !rst && ((state == IDLE) || at_last);
        cmp_rst   = rst || (state == CLR);
        out_valid = !rst && (state == SHIFT);
        out_a     = out_valid && head_a;
        out_b     = out_valid && head_b;
        out_first = out_valid && (cnt == '0);
        out_last  = out_valid && (cnt == LAST_BIT);
    end

    // Operand capture, head-ward shifting and bit counting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sh_a <= '0;
            sh_b <= '0;
        end else begin
            if (xfer) begin
                sh_a <= in_a;
                sh_b <= in_b;
            end else if (state == SHIFT) begin
                sh_a <= MSB_FIRST ? (sh_a << 1) : (sh_a >> 1);
                sh_b <= MSB_FIRST ? (sh_b << 1) : (sh_b >> 1);
            end
            if ((state == SHIFT) && !at_last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_pair_serializer.sv
// tb/tb_serial_pair_serializer.sv - randomized scoreboard bench for serial_pair_serializer
module tb_serial_pair_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;

    logic       rdy_m, crst_m, ov_m, oa_m, ob_m, of_m, ol_m;
    logic       rdy_l, crst_l, ov_l, oa_l, ob_l, of_l, ol_l;
    logic       rdy_1, crst_1, ov_1, oa_1, ob_1, of_1, ol_1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_pair_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m),
        .in_a(in_a), .in_b(in_b), .cmp_rst(crst_m), .out_valid(ov_m),
        .out_a(oa_m), .out_b(ob_m), .out_first(of_m), .out_last(ol_m)
    );

    serial_pair_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
        .in_a(in_a), .in_b(in_b), .cmp_rst(crst_l), .out_valid(ov_l),
        .out_a(oa_l), .out_b(ob_l), .out_first(of_l), .out_last(ol_l)
    );

    serial_pair_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_1),
        .in_a(in_a[0]), .in_b(in_b[0]), .cmp_rst(crst_1), .out_valid(ov_1),
        .out_a(oa_1), .out_b(ob_1), .out_first(of_1), .out_last(ol_1)
    );

    // Reference model: each word is WIDTH+1 busy cycles (1 clear + WIDTH bits);
    // rem counts busy cycles left, accept allowed when idle or on the final bit.
    // Expected bit records are {a, b, first, last}.
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];
    logic [3:0] q_1[$];
    int rem_m = 0, rem_l = 0, rem_1 = 0;
    bit acc_m = 0;

    always @(posedge clk) begin
        if (rst) begin
            rem_m = 0; rem_l = 0; rem_1 = 0; acc_m = 0;
            q_m.delete(); q_l.delete(); q_1.delete();
        end else begin
            acc_m = in_valid && (rem_m <= 1);
            if (acc_m) begin
                for (int i = 7; i >= 0; i--)
                    q_m.push_back({in_a[i], in_b[i], i == 7, i == 0});
                rem_m = 9;
            end else if (rem_m > 0) rem_m--;
            if (in_valid && (rem_l <= 1)) begin
                for (int k = 0; k < 8; k++)
                    q_l.push_back({in_a[k], in_b[k], k == 0, k == 7});
                rem_l = 9;
            end else if (rem_l > 0) rem_l--;
            if (in_valid && (rem_1 <= 1)) begin
                q_1.push_back({in_a[0], in_b[0], 1'b1, 1'b1});
                rem_1 = 2;
            end else if (rem_1 > 0) rem_1--;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic mon(input string tag, input int rem, input int w,
                       input logic rdy, input logic crst, input logic ov,
                       input logic [3:0] bits, input logic [3:0] exp_bits,
                       input bit have);
        chk({tag, "_in_ready"}, int'(rdy), int'(!rst && rem <= 1));
        chk({tag, "_cmp_rst"}, int'(crst), int'(rst || rem == w + 1));
        chk({tag, "_out_valid"}, int'(ov), int'(!rst && rem >= 1 && rem <= w));
        if (ov) begin
            chk({tag, "_queue_has_bit"}, int'(have), 1);
            if (have) chk({tag, "_bits"}, int'(bits), int'(exp_bits));
        end else begin
            chk({tag, "_idle_bits"}, int'(bits), 0);
        end
    endtask

    // Monitor: samples mid-cycle and pops the scoreboard when a bit is presented
    always @(negedge clk) begin
        logic [3:0] e;
        bit h;
        h = 0; e = 4'h0;
        if (ov_m && q_m.size() > 0) begin e = q_m.pop_front(); h = 1; end
        mon("msb", rem_m, 8, rdy_m, crst_m, ov_m, {oa_m, ob_m, of_m, ol_m}, e, h);
        h = 0; e = 4'h0;
        if (ov_l && q_l.size() > 0) begin e = q_l.pop_front(); h = 1; end
        mon("lsb", rem_l, 8, rdy_l, crst_l, ov_l, {oa_l, ob_l, of_l, ol_l}, e, h);
        h = 0; e = 4'h0;
        if (ov_1 && q_1.size() > 0) begin e = q_1.pop_front(); h = 1; end
        mon("w1", rem_1, 1, rdy_1, crst_1, ov_1, {oa_1, ob_1, of_1, ol_1}, e, h);
    end

    logic [15:0] dir_pairs[6];

    initial begin
        int idx;
        int guard;
        dir_pairs[0] = 16'hA55A; dir_pairs[1] = 16'h3C3D; dir_pairs[2] = 16'hF00F;
        dir_pairs[3] = 16'h0180; dir_pairs[4] = 16'h807F; dir_pairs[5] = 16'h5555;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Directed words with in_valid held high: back-to-back on the msb instance
        idx = 0;
        {in_a, in_b} = dir_pairs[0];
        in_valid = 1'b1;
        guard = 0;
        while (idx < 6 && guard < 200) begin
            @(posedge clk); #2;
            guard++;
            if (acc_m) begin
                idx++;
                if (idx < 6) {in_a, in_b} = dir_pairs[idx];
                else in_valid = 1'b0;
            end
        end
        chk("directed_done", idx, 6);

        // Mid-word reset on bit 4, then a clean word
        guard = 0;
        while (rem_m != 5 && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("reach_bit4", rem_m, 5);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        {in_a, in_b} = 16'h1212;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        {in_a, in_b} = 16'hFFFF;
        repeat (12) begin @(posedge clk); #2; end

        // Random traffic with occasional resets; operands churn every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            in_valid = ($urandom_range(0, 99) < 60);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            rst = ($urandom_range(0, 99) < 2);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("drain_msb", q_m.size(), 0);
        chk("drain_lsb", q_l.size(), 0);
        chk("drain_w1", q_1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
